// File: rtl/sram_load_arb_pkg.sv
// Shared types for the SRAM load/arbitration front end.
// Phase encoding and host-id width helper.
package sram_load_arb_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } phase_e;

  localparam int MaxHosts = 4;

  function automatic int host_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_rr_arb.sv
// Round-robin arbiter: one-hot grant, winner index,
// pointer moves to winner+1 when enabled.
module sram_rr_arb
  import sram_load_arb_pkg::*;
#(
  parameter int NumHosts = 2,
  parameter int IdW      = host_id_w(NumHosts)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [NumHosts-1:0] req_i,
  output logic [NumHosts-1:0] gnt_o,
  output logic [IdW-1:0]      idx_o,
  output logic                any_o
);

  logic [IdW-1:0] ptr_q;
  logic [IdW-1:0] cand;
  logic [IdW-1:0] win;
  logic           found;

  always_comb begin
    cand  = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NumHosts; k++) begin
      cand = IdW'((int'(ptr_q) + k) % NumHosts);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (found) gnt_o[win] = 1'b1;
  end

  assign idx_o = win;
  assign any_o = found;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (en_i && found) begin
      ptr_q <= (win == IdW'(NumHosts - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/sram_load_arb.sv
// SRAM front end: boot-time loader phase, then round-robin
// host access with fixed-latency read responses.
module sram_load_arb
  import sram_load_arb_pkg::*;
#(
  parameter int DataW       = 32,
  parameter int AddrW       = 11,
  parameter int NumHosts    = 2,
  parameter int ReadLatency = 1,
  parameter int LockWrites  = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ld_valid_i,
  output logic                      ld_ready_o,
  input  logic [AddrW-1:0]          ld_addr_i,
  input  logic [DataW-1:0]          ld_wdata_i,
  input  logic [DataW-1:0]          ld_wmask_i,
  input  logic                      ld_done_i,
  output logic                      run_o,
  output logic [AddrW:0]            ld_count_o,
  input  logic [NumHosts-1:0]       host_req_i,
  output logic [NumHosts-1:0]       host_gnt_o,
  input  logic [NumHosts-1:0]       host_we_i,
  input  logic [NumHosts*AddrW-1:0] host_addr_i,
  input  logic [NumHosts*DataW-1:0] host_wdata_i,
  input  logic [NumHosts*DataW-1:0] host_wmask_i,
  output logic [NumHosts-1:0]       host_rvalid_o,
  output logic [DataW-1:0]          host_rdata_o,
  output logic                      lock_viol_o,
  output logic                      mem_en_o,
  output logic                      mem_we_o,
  output logic [AddrW-1:0]          mem_addr_o,
  output logic [DataW-1:0]          mem_wdata_o,
  output logic [DataW-1:0]          mem_wmask_o,
  input  logic [DataW-1:0]          mem_rdata_i
);

  localparam int IdW = host_id_w(NumHosts);
  localparam bit Lock = (LockWrites != 0);
  localparam logic [AddrW:0] CntMax = {1'b1, {AddrW{1'b0}}};

  phase_e state_q, state_d;
  logic   run;

  logic [NumHosts-1:0] arb_req;
  logic [IdW-1:0]      win;
  logic                found;
  logic                sel_we;
  logic                rd_go;
  logic                hw_go;

  logic [AddrW:0]          cnt_q;
  logic                    viol_q;
  logic [ReadLatency-1:0]  vld_q;
  logic [IdW-1:0]          id_q [ReadLatency];

  assign run     = (state_q == RUN);
  assign arb_req = run ? host_req_i : '0;

  sram_rr_arb #(
    .NumHosts(NumHosts),
    .IdW     (IdW)
  ) u_arb (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en_i (run),
    .req_i(arb_req),
    .gnt_o(host_gnt_o),
    .idx_o(win),
    .any_o(found)
  );

  assign sel_we = host_we_i[win];
  assign rd_go  = found && !sel_we;
  assign hw_go  = found && sel_we;

  always_comb begin
    state_d = state_q;
    if (state_q == LOAD && ld_done_i) state_d = RUN;
  end

  // Loader owns the macro in LOAD; the arbiter winner in RUN.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = host_addr_i[win*AddrW +: AddrW];
    mem_wdata_o = host_wdata_i[win*DataW +: DataW];
    mem_wmask_o = host_wmask_i[win*DataW +: DataW];
    if (!run) begin
      mem_en_o    = ld_valid_i;
      mem_we_o    = ld_valid_i;
      mem_addr_o  = ld_addr_i;
      mem_wdata_o = ld_wdata_i;
      mem_wmask_o = ld_wmask_i;
    end else if (found) begin
      mem_en_o = rd_go || (hw_go && !Lock);
      mem_we_o = hw_go && !Lock;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      viol_q  <= 1'b0;
      vld_q   <= '0;
      for (int i = 0; i < ReadLatency; i++) id_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (!run && ld_valid_i && cnt_q != CntMax) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (hw_go && Lock) viol_q <= 1'b1;
      vld_q[0] <= rd_go;
      id_q[0]  <= win;
      for (int i = 1; i < ReadLatency; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  always_comb begin
    host_rvalid_o = '0;
    host_rdata_o  = '0;
    if (vld_q[ReadLatency-1]) begin
      host_rvalid_o[id_q[ReadLatency-1]] = 1'b1;
      host_rdata_o = mem_rdata_i;
    end
  end

  assign ld_ready_o  = !run;
  assign run_o       = run;
  assign ld_count_o  = cnt_q;
  assign lock_viol_o = viol_q;

endmodule

// File: tb/tb_sram_load_arb.sv
// Randomised scoreboard bench for sram_load_arb with a
// behavioural macro model and reference memory.
module tb_sram_load_arb;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NH = 2;
  localparam int RL = 2;
  localparam int LW = 1;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ld_valid = 1'b0;
  logic ld_ready;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_wdata = '0;
  logic [DW-1:0] ld_wmask = '0;
  logic ld_done = 1'b0;
  logic run;
  logic [AW:0] ld_count;
  logic [NH-1:0] host_req = '0;
  logic [NH-1:0] host_gnt;
  logic [NH-1:0] host_we = '0;
  logic [NH*AW-1:0] host_addr = '0;
  logic [NH*DW-1:0] host_wdata = '0;
  logic [NH*DW-1:0] host_wmask = '0;
  logic [NH-1:0] host_rvalid;
  logic [DW-1:0] host_rdata;
  logic lock_viol;
  logic mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_wmask, mem_rdata;

  always #5 clk = ~clk;

  sram_load_arb #(
    .DataW(DW), .AddrW(AW), .NumHosts(NH),
    .ReadLatency(RL), .LockWrites(LW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .ld_valid_i(ld_valid), .ld_ready_o(ld_ready),
    .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata),
    .ld_wmask_i(ld_wmask), .ld_done_i(ld_done),
    .run_o(run), .ld_count_o(ld_count),
    .host_req_i(host_req), .host_gnt_o(host_gnt),
    .host_we_i(host_we), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_wmask_i(host_wmask),
    .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata),
    .lock_viol_o(lock_viol),
    .mem_en_o(mem_en), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_wmask_o(mem_wmask), .mem_rdata_i(mem_rdata)
  );

  // Macro model: masked write, fixed-latency read.
  logic [DW-1:0] sram [DEPTH];
  logic [DW-1:0] rpipe [RL];

  always @(posedge clk) begin
    if (mem_en && mem_we)
      sram[mem_addr] <= (sram[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
    rpipe[0] <= (mem_en && !mem_we) ? sram[mem_addr] : 32'hBAD0_BAD0;
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[RL-1];

  typedef struct {
    int           host;
    logic [DW-1:0] data;
    int           due;
  } rsp_t;

  typedef struct {
    logic [NH-1:0] gnt;
    logic          en;
    logic          we;
    logic          run;
    logic          rdy;
    logic          lock;
    logic [AW:0]   cnt;
  } cyc_t;

  rsp_t rq[$];
  cyc_t cq[$];

  logic [DW-1:0] ref_mem [DEPTH];
  bit run_m = 0;
  bit lock_m = 0;
  int cnt_m = 0;
  int ptr_m = 0;
  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  cyc_t me;
  rsp_t mr;

  always @(negedge clk) begin
    if (!rst) begin
      if (cq.size() > 0) begin
        me = cq.pop_front();
        chk("gnt", 64'(host_gnt), 64'(me.gnt));
        chk("mem_en", 64'(mem_en), 64'(me.en));
        chk("mem_we", 64'(mem_we), 64'(me.we));
        chk("run", 64'(run), 64'(me.run));
        chk("ld_ready", 64'(ld_ready), 64'(me.rdy));
        chk("lock_viol", 64'(lock_viol), 64'(me.lock));
        chk("ld_count", 64'(ld_count), 64'(me.cnt));
      end
      if (host_rvalid != '0) begin
        if (rq.size() == 0) begin
          chk("spurious_rvalid", 64'(host_rvalid), 64'(0));
        end else begin
          mr = rq.pop_front();
          chk("rv_host", 64'(host_rvalid), 64'(1) << mr.host);
          chk("rv_data", 64'(host_rdata), 64'(mr.data));
          chk("rv_cycle", 64'(cyc), 64'(mr.due));
        end
      end else begin
        chk("rdata_idle", 64'(host_rdata), 64'(0));
        if (rq.size() > 0 && rq[0].due <= cyc) begin
          mr = rq.pop_front();
          chk("rv_missing", 64'(host_rvalid), 64'(1) << mr.host);
        end
      end
    end
  end

  task automatic step(
    input logic          ldv,
    input logic [AW-1:0] la,
    input logic [DW-1:0] ld,
    input logic [DW-1:0] lm,
    input logic          done,
    input logic [NH-1:0] req,
    input logic [NH-1:0] we,
    input logic [AW-1:0] a0,
    input logic [AW-1:0] a1,
    input logic [DW-1:0] wd
  );
    cyc_t e;
    int w;
    int h;
    @(posedge clk);
    #1;
    ld_valid   = ldv;
    ld_addr    = la;
    ld_wdata   = ld;
    ld_wmask   = lm;
    ld_done    = done;
    host_req   = req;
    host_we    = we;
    host_addr  = {a1, a0};
    host_wdata = {wd, wd};
    host_wmask = '1;
    e.run  = run_m;
    e.rdy  = !run_m;
    e.cnt  = (AW+1)'(cnt_m);
    e.lock = lock_m;
    e.gnt  = '0;
    e.en   = 1'b0;
    e.we   = 1'b0;
    if (!run_m) begin
      e.en = ldv;
      e.we = ldv;
      if (ldv) begin
        ref_mem[la] = (ref_mem[la] & ~lm) | (ld & lm);
        if (cnt_m < DEPTH) cnt_m++;
      end
      if (done) run_m = 1;
    end else begin
      w = -1;
      for (int k = 0; k < NH; k++) begin
        h = (ptr_m + k) % NH;
        if (w < 0 && req[h]) w = h;
      end
      if (w >= 0) begin
        e.gnt = NH'(1 << w);
        ptr_m = (w + 1) % NH;
        if (we[w]) begin
          lock_m = 1;
        end else begin
          e.en = 1'b1;
          rq.push_back('{w, ref_mem[(w == 1) ? a1 : a0], cyc + RL});
        end
      end
    end
    cq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, '0, 0, '0, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    ld_valid = 1'b0;
    ld_done  = 1'b0;
    host_req = '1;
    host_we  = '0;
    cq.delete();
    @(posedge clk);
    #1;
    rq.delete();
    run_m = 0;
    cnt_m = 0;
    lock_m = 0;
    ptr_m = 0;
    @(negedge clk);
    chk("rst_run", 64'(run), 64'(0));
    chk("rst_count", 64'(ld_count), 64'(0));
    chk("rst_lock", 64'(lock_viol), 64'(0));
    chk("rst_gnt", 64'(host_gnt), 64'(0));
    chk("rst_rvalid", 64'(host_rvalid), 64'(0));
    chk("rst_mem_en", 64'(mem_en), 64'(0));
    chk("rst_ready", 64'(ld_ready), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    host_req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout @cyc %0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [NH-1:0] rreq, rwe;
    for (int i = 0; i < DEPTH; i++) begin
      sram[i] = '0;
      ref_mem[i] = '0;
    end
    for (int i = 0; i < RL; i++) rpipe[i] = '0;

    do_reset();

    // Boot image words, host 0 stalled meanwhile.
    for (int i = 0; i < 4; i++)
      step(1, AW'(i), DW'(32'hA0 + i), '1, 0, 2'b01, '0, '0, '0, '0);

    // Random loader traffic above addr 3; drives count to saturation.
    for (int i = 0; i < 30; i++)
      step(($urandom % 4) != 0, AW'(4 + $urandom % 12), $urandom, $urandom,
           0, 2'b01, '0, '0, '0, '0);

    step(0, '0, '0, '0, 1, 2'b01, '0, '0, '0, '0);
    step(0, '0, '0, '0, 0, 2'b01, '0, AW'(2), '0, '0);

    for (int i = 0; i < 6; i++)
      step(0, '0, '0, '0, 0, 2'b11, '0, AW'($urandom), AW'($urandom), '0);

    step(0, '0, '0, '0, 0, 2'b10, 2'b10, '0, AW'(1), 32'hDEAD);
    step(0, '0, '0, '0, 0, 2'b10, 2'b00, '0, AW'(1), '0);

    for (int i = 0; i < 200; i++) begin
      rreq = NH'($urandom);
      rwe  = NH'(($urandom % 4 == 0) ? $urandom : 0);
      step($urandom % 2 == 1, AW'($urandom), $urandom, $urandom, $urandom % 2 == 1,
           rreq, rwe, AW'($urandom), AW'($urandom), $urandom);
    end
    idle(6);
    chk("drain1", 64'(rq.size()), 64'(0));

    step(0, '0, '0, '0, 0, 2'b01, '0, AW'(3), '0, '0);
    step(0, '0, '0, '0, 0, 2'b10, '0, '0, AW'(0), '0);
    do_reset();
    idle(5);

    step(1, AW'(5), 32'h5555_AAAA, '1, 1, 2'b11, '0, '0, '0, '0);
    step(0, '0, '0, '0, 0, 2'b01, '0, AW'(5), '0, '0);
    step(0, '0, '0, '0, 0, 2'b11, '0, AW'(2), AW'(1), '0);
    idle(6);
    chk("drain2", 64'(rq.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
